// File: rtl/hough_pixel_reader.sv
// rtl/hough_pixel_reader.sv - row-major BRAM scan emitting coordinates of pixels at or above a threshold
// Optional edge counter output enabled by defining HOUGH_READER_CNT_EN.
module hough_pixel_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  width_i,
  input  logic [8:0]  height_i,
  input  logic [7:0]  threshold,
  output logic        ready,
  output logic [16:0] bram_addr_o,
  output logic        bram_en_o,
  input  logic [7:0]  bram_data_i,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic [8:0]  pix_x_o,
  output logic [8:0]  pix_y_o,
  output logic        done_o
`ifdef HOUGH_READER_CNT_EN
  ,
  output logic [17:0] edge_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CMP,
    S_EMIT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [8:0]  width_r;
  logic [8:0]  height_r;
  logic [7:0]  thr_r;
  logic [8:0]  x;
  logic [8:0]  y;
  logic [16:0] addr;

  logic        accept;
  logic        hit;
  logic        advance;
  logic        x_last;
  logic        last_pix;

  assign x_last   = (x == width_r - 9'd1);
  assign last_pix = x_last && (y == height_r - 9'd1);

  assign ready       = (state == S_IDLE);
  assign bram_en_o   = (state == S_FETCH);
  assign pix_valid_o = (state == S_EMIT);
  assign done_o      = (state == S_DONE);
  assign bram_addr_o = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    hit       = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (width_i != 9'd0 && height_i != 9'd0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: state_nxt = S_CMP;
      S_CMP: begin
        if (bram_data_i >= thr_r) begin
          hit       = 1'b1;
          state_nxt = S_EMIT;
        end else begin
          advance = 1'b1;
        end
      end
      S_EMIT: begin
        if (pix_ready_i) advance = 1'b1;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (advance) state_nxt = last_pix ? S_DONE : S_FETCH;
  end

  // Address is a plain counter; oversized images simply wrap at 2^17.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_r  <= 9'd0;
      height_r <= 9'd0;
      thr_r    <= 8'd0;
      x        <= 9'd0;
      y        <= 9'd0;
      addr     <= 17'd0;
      pix_x_o  <= 9'd0;
      pix_y_o  <= 9'd0;
    end else begin
      if (accept) begin
        width_r  <= width_i;
        height_r <= height_i;
        thr_r    <= threshold;
        x        <= 9'd0;
        y        <= 9'd0;
        addr     <= 17'd0;
      end
      if (hit) begin
        pix_x_o <= x;
        pix_y_o <= y;
      end
      if (advance && !last_pix) begin
        addr <= addr + 17'd1;
        if (x_last) begin
          x <= 9'd0;
          y <= y + 9'd1;
        end else begin
          x <= x + 9'd1;
        end
      end
    end
  end

`ifdef HOUGH_READER_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_o <= 18'd0;
    end else if (accept) begin
      edge_cnt_o <= 18'd0;
    end else if (state == S_EMIT && pix_ready_i) begin
      edge_cnt_o <= edge_cnt_o + 18'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hough_pixel_reader.sv
// tb/tb_hough_pixel_reader.sv - directed self-checking bench for hough_pixel_reader
module tb_hough_pixel_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  width_i = 9'd0;
  logic [8:0]  height_i = 9'd0;
  logic [7:0]  threshold = 8'd0;
  logic        ready;
  logic [16:0] bram_addr_o;
  logic        bram_en_o;
  logic [7:0]  bram_data = 8'd0;
  logic        pix_valid_o;
  logic        pix_ready = 1'b1;
  logic [8:0]  pix_x_o;
  logic [8:0]  pix_y_o;
  logic        done_o;
`ifdef HOUGH_READER_CNT_EN
  logic [17:0] edge_cnt;
`endif

  logic [7:0]  mem [0:31];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int base = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int addr_q[$];
  int ex_q[$];
  int ey_q[$];
  int ec_q[$];

  hough_pixel_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .width_i     (width_i),
    .height_i    (height_i),
    .threshold   (threshold),
    .ready       (ready),
    .bram_addr_o (bram_addr_o),
    .bram_en_o   (bram_en_o),
    .bram_data_i (bram_data),
    .pix_valid_o (pix_valid_o),
    .pix_ready_i (pix_ready),
    .pix_x_o     (pix_x_o),
    .pix_y_o     (pix_y_o),
    .done_o      (done_o)
`ifdef HOUGH_READER_CNT_EN
    ,
    .edge_cnt_o  (edge_cnt)
`endif
  );

  always #5 clk = ~clk;

  // one-cycle read latency BRAM
  always @(posedge clk) begin
    if (bram_en_o) bram_data <= mem[bram_addr_o[4:0]];
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bram_en_o) addr_q.push_back(int'(bram_addr_o));
    if (pix_valid_o && pix_ready) begin
      ex_q.push_back(int'(pix_x_o));
      ey_q.push_back(int'(pix_y_o));
      ec_q.push_back(cyc - base);
    end
    if (done_o) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc - base;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_scan(input int w, input int h, input int t);
    step();
    width_i   = 9'(w);
    height_i  = 9'(h);
    threshold = 8'(t);
    start     = 1'b1;
    addr_q.delete();
    ex_q.delete();
    ey_q.delete();
    ec_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    @(posedge clk);
    base = cyc;
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, done_cnt, 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'd0;

    // reset state
    step();
    step();
    chk("rst_ready", int'(ready), 1);
    chk("rst_en", int'(bram_en_o), 0);
    chk("rst_valid", int'(pix_valid_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_addr", int'(bram_addr_o), 0);
    chk("rst_x", int'(pix_x_o), 0);
    chk("rst_y", int'(pix_y_o), 0);
    rst = 1'b0;
    step();

    // 2x2 {10,200,50,255}, threshold 100
    mem[0] = 8'd10; mem[1] = 8'd200; mem[2] = 8'd50; mem[3] = 8'd255;
    pix_ready = 1'b1;
    start_scan(2, 2, 100);
    wait_done("s1_done_seen", 40);
    chk("s1_done_cyc", done_cyc, 11);
    step();
    chk("s1_ready_cyc", cyc - base, 12);
    chk("s1_ready", int'(ready), 1);
    chk("s1_emit_n", ex_q.size(), 2);
    if (ex_q.size() == 2) begin
      chk("s1_e0_x", ex_q[0], 1);
      chk("s1_e0_y", ey_q[0], 0);
      chk("s1_e0_cyc", ec_q[0], 5);
      chk("s1_e1_x", ex_q[1], 1);
      chk("s1_e1_y", ey_q[1], 1);
      chk("s1_e1_cyc", ec_q[1], 10);
    end
    chk("s1_addr_n", addr_q.size(), 4);
    for (int i = 0; i < addr_q.size() && i < 4; i++) chk("s1_addr_seq", addr_q[i], i);

    // 3x1 zeros, threshold 0: every pixel emits
    mem[0] = 8'd0; mem[1] = 8'd0; mem[2] = 8'd0;
    start_scan(3, 1, 0);
    wait_done("s2_done_seen", 40);
    chk("s2_emit_n", ex_q.size(), 3);
    for (int i = 0; i < ex_q.size() && i < 3; i++) begin
      chk("s2_ex", ex_q[i], i);
      chk("s2_ey", ey_q[i], 0);
    end
    chk("s2_addr_n", addr_q.size(), 3);
    for (int i = 0; i < addr_q.size() && i < 3; i++) chk("s2_addr_seq", addr_q[i], i);

    // backpressure on the first emit of the 2x2 image
    mem[0] = 8'd10; mem[1] = 8'd200; mem[2] = 8'd50; mem[3] = 8'd255;
    pix_ready = 1'b0;
    start_scan(2, 2, 100);
    begin
      int n;
      n = 0;
      while (!pix_valid_o && n < 40) begin
        step();
        n++;
      end
    end
    chk("bp_valid_seen", int'(pix_valid_o), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_hold", int'(pix_valid_o), 1);
      chk("bp_x_hold", int'(pix_x_o), 1);
      chk("bp_y_hold", int'(pix_y_o), 0);
      chk("bp_no_en", int'(bram_en_o), 0);
    end
    chk("bp_addr_n", addr_q.size(), 2);
    pix_ready = 1'b1;
    step();
    chk("bp_resume_en", int'(bram_en_o), 1);
    chk("bp_resume_addr", int'(bram_addr_o), 2);
    wait_done("bp_done_seen", 40);

    // zero width
    start_scan(0, 4, 0);
    wait_done("z_done_seen", 10);
    chk("z_done_cyc", done_cyc, 1);
    chk("z_en_n", addr_q.size(), 0);
    chk("z_emit_n", ex_q.size(), 0);

    // start mid-scan with other dimensions must be ignored
    mem[0] = 8'd10; mem[1] = 8'd200; mem[2] = 8'd50; mem[3] = 8'd255;
    start_scan(2, 2, 100);
    step();
    step();
    width_i   = 9'd5;
    height_i  = 9'd7;
    threshold = 8'd0;
    start     = 1'b1;
    step();
    start = 1'b0;
    wait_done("m_done_seen", 40);
    chk("m_done_cyc", done_cyc, 11);
    chk("m_emit_n", ex_q.size(), 2);
    chk("m_addr_n", addr_q.size(), 4);
`ifdef HOUGH_READER_CNT_EN
    chk("m_edge_cnt", int'(edge_cnt), 2);
`endif

    // reset while stalled in EMIT of a 4x4 scan
    for (int i = 0; i < 16; i++) mem[i] = 8'd255;
    pix_ready = 1'b0;
    start_scan(4, 4, 0);
    begin
      int n;
      n = 0;
      while (!pix_valid_o && n < 40) begin
        step();
        n++;
      end
    end
    chk("r_valid_seen", int'(pix_valid_o), 1);
    rst = 1'b1;
    #1;
    chk("r_valid_off", int'(pix_valid_o), 0);
    chk("r_ready_on", int'(ready), 1);
    chk("r_en_off", int'(bram_en_o), 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("r_no_done", done_cnt, 0);
    pix_ready = 1'b1;
    start_scan(4, 4, 0);
    wait_done("r_rescan_done", 100);
    chk("r_addr_n", addr_q.size(), 16);
    if (addr_q.size() > 0) chk("r_addr_first", addr_q[0], 0);
    if (addr_q.size() == 16) chk("r_addr_last", addr_q[15], 15);
    chk("r_emit_n", ex_q.size(), 16);
    if (ex_q.size() == 16) begin
      chk("r_last_x", ex_q[15], 3);
      chk("r_last_y", ey_q[15], 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hough_pixel_reader.md
HOUGH_PIXEL_READER -- requirements
Module: hough_pixel_reader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 start  in  1  begin a scan; sampled only while ready=1.
REQ-005 width_i  in  9  image width in pixels, latched on accepted start.
REQ-006 height_i  in  9  image height in pixels, latched on accepted start.
REQ-007 threshold  in  8  edge threshold, latched on accepted start.
REQ-008 ready  out  1  high only in IDLE.
REQ-009 bram_addr_o  out  17  pixel read address, row-major.
REQ-010 bram_en_o  out  1  read enable; data valid on bram_data_i exactly one cycle later.
REQ-011 bram_data_i  in  8  pixel read data.
REQ-012 pix_valid_o  out  1  edge-pixel coordinate valid.
REQ-013 pix_ready_i  in  1  downstream accepts coordinate.
REQ-014 pix_x_o  out  9  column of emitted pixel.
REQ-015 pix_y_o  out  9  row of emitted pixel.
REQ-016 done_o  out  1  one-cycle pulse at scan end.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, CMP, EMIT, DONE.
REQ-018 IDLE: start=1 with width and height nonzero -> FETCH, with x=0, y=0, addr=0; start=1 with either dimension zero -> DONE, with no read issued.
REQ-019 FETCH SHALL assert bram_en_o=1 with bram_addr_o=addr for one cycle, then go to CMP.
REQ-020 CMP SHALL compare bram_data_i (unsigned) >= latched threshold; true -> EMIT with pix_x_o=x, pix_y_o=y registered; false -> advance.
REQ-021 EMIT SHALL hold pix_valid_o=1 and pix_x_o/pix_y_o stable until the cycle pix_valid_o and pix_ready_i are both 1, then advance.
REQ-022 Advance: on the last pixel (x=width-1, y=height-1) -> DONE; otherwise -> FETCH with addr+1, x+1, or x=0 and y+1 when x=width-1.
REQ-023 Addresses SHALL be produced by an incrementing counter, with no multiplier.
REQ-024 width*height > 131072 is an illegal configuration; for such a configuration the address SHALL wrap modulo 2^17 and no error is flagged.
REQ-025 DONE SHALL assert done_o=1 for exactly one cycle, then go to IDLE.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 Changes on width_i, height_i or threshold during a scan SHALL have no effect.
REQ-028 bram_en_o SHALL be 0 in every state except FETCH.
REQ-029 pix_valid_o SHALL be 0 in every state except EMIT.
REQ-030 Per-pixel cost SHALL be 2 cycles, plus EMIT cycles for emitted pixels.

Reset
REQ-031 While rst=1, the block SHALL be in IDLE with ready=1 and with bram_en_o, pix_valid_o and done_o all 0.
REQ-032 While rst=1, bram_addr_o, pix_x_o, pix_y_o and all internal counters and latched values SHALL be 0.
REQ-033 Reset asserted mid-scan SHALL abort the scan immediately, with no done_o pulse.

Configuration
REQ-034 With HOUGH_READER_CNT_EN defined, the block SHALL add output edge_cnt_o (18 bits).
REQ-035 edge_cnt_o SHALL clear to 0 on reset and on accepted start, and increment on each pix_valid_o/pix_ready_i handshake.
REQ-036 Without HOUGH_READER_CNT_EN, the port and its counter SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-037 2x2 image {10,200,50,255}, threshold=100, pix_ready_i=1, start sampled at cycle 0 -> required response:
- emits (1,0) at cycle 5 and (1,1) at cycle 10;
- done_o at cycle 11;
- ready=1 at cycle 12;
- bram_addr_o sequence 0,1,2,3.
REQ-038 3x1 image {0,0,0}, threshold=0 -> required response: emits (0,0),(1,0),(2,0) in order with addresses 0,1,2.
REQ-039 Backpressure: pix_ready_i=0 for 5 cycles during EMIT -> required response:
- pix_valid_o stays 1 and coordinates are unchanged;
- no bram_en_o is issued;
- the scan resumes on the cycle after the handshake.
REQ-040 Zero dimension: width_i=0, height_i=4, start at cycle 0 -> required response:
- done_o at cycle 1;
- bram_en_o never asserted;
- no pixel emitted.
REQ-041 Reset during EMIT in a 4x4 scan -> required response:
- pix_valid_o=0 and ready=1 immediately;
- no done_o;
- a new start rescans from addr 0.
REQ-042 start pulsed mid-scan with width_i changed -> required response: ignored, and the original scan completes with its latched dimensions; with HOUGH_READER_CNT_EN defined, edge_cnt_o=2 after the REQ-037 scan.
